// File: rtl/alu_exec_if.sv
// alu_exec_if: request/result handshake bundle between the decode stage and the execute ALU.
interface alu_exec_if #(
   parameter int XLEN = 32
);
   logic            valid_i, ready_o, flush_i, valid_o, ready_i, illegal_o;
   logic [5:0]      alu_op_i;
   logic [XLEN-1:0] op_a_i, op_b_i, result_o;
   modport slave (
      input  valid_i, alu_op_i, op_a_i, op_b_i, flush_i, ready_i,
      output ready_o, valid_o, result_o, illegal_o
   );
   modport master (
      output valid_i, alu_op_i, op_a_i, op_b_i, flush_i, ready_i,
      input  ready_o, valid_o, result_o, illegal_o
   );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshake and a held result register.
// Define ALU_FAST_SHIFT_EN for single-cycle barrel shifts; otherwise shifts iterate one bit per cycle.
module alu_exec_unit #(
   parameter int XLEN = 32
) (
   input logic       clk_i,
   input logic       rst_ni,
   alu_exec_if.slave bus
);
`ifdef ALU_FAST_SHIFT_EN
   localparam bit fast_shift = 1'b1;
`else
   localparam bit fast_shift = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
   state_e          state_q, state_d;
   logic [XLEN-1:0] res_q, res_d, wrk_q, wrk_d, alu_r, shf_nxt, a, b;
   logic            ill_q, ill_d, lt_s, lt_u, eq, is_shift, go_shift;
   logic [4:0]      cnt_q, cnt_d, amt;
   logic [1:0]      kind_q, kind_d;
   logic [5:0]      op;

   function automatic logic [XLEN-1:0] flag(input logic f);
      return {{(XLEN-1){1'b0}}, f};
   endfunction

   assign op       = bus.alu_op_i;
   assign a        = bus.op_a_i;
   assign b        = bus.op_b_i;
   assign amt      = b[4:0];
   assign lt_s     = $signed(a) < $signed(b);
   assign lt_u     = a < b;
   assign eq       = a == b;
   assign is_shift = op == 6'd2 || op == 6'd6 || op == 6'd7;
   assign go_shift = !fast_shift && is_shift && amt != 5'd0;
   // kind_q: bit1 = shift right, bit0 = arithmetic fill
   assign shf_nxt  = kind_q[1] ? {kind_q[0] & wrk_q[XLEN-1], wrk_q[XLEN-1:1]} : {wrk_q[XLEN-2:0], 1'b0};

   assign bus.ready_o   = state_q == IDLE;
   assign bus.valid_o   = state_q == DONE;
   assign bus.result_o  = res_q;
   assign bus.illegal_o = ill_q;

   always_comb begin
      alu_r = '0;
      case (op)
         6'd0, 6'd1: alu_r = a + b;
         6'd2:       alu_r = fast_shift ? a << amt : a;
         6'd3:       alu_r = flag(lt_s);
         6'd4:       alu_r = flag(lt_u);
         6'd5:       alu_r = a ^ b;
         6'd6:       alu_r = fast_shift ? a >> amt : a;
         6'd7:       alu_r = fast_shift ? $unsigned($signed(a) >>> amt) : a;
         6'd8:       alu_r = a | b;
         6'd9:       alu_r = a & b;
         6'd10:      alu_r = a - b;
         6'd11:      alu_r = flag(eq);
         6'd12:      alu_r = flag(!eq);
         6'd13:      alu_r = flag(lt_s);
         6'd14:      alu_r = flag(!lt_s);
         6'd15:      alu_r = flag(lt_u);
         6'd16:      alu_r = flag(!lt_u);
         6'd17:      alu_r = a + XLEN'(4);
         default:    alu_r = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      ill_d   = ill_q;
      wrk_d   = wrk_q;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      if (bus.flush_i) state_d = IDLE;
      else case (state_q)
         IDLE: if (bus.valid_i) begin
            if (go_shift) begin
               wrk_d   = a;
               cnt_d   = amt;
               kind_d  = {op[2], op[0]};
               state_d = SHIFT;
            end else begin
               res_d   = alu_r;
               ill_d   = op > 6'd17;
               state_d = DONE;
            end
         end
         SHIFT: begin
            wrk_d = shf_nxt;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               res_d   = shf_nxt;
               ill_d   = 1'b0;
               state_d = DONE;
            end
         end
         DONE: if (bus.ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         res_q   <= '0;
         ill_q   <= 1'b0;
         wrk_q   <= '0;
         cnt_q   <= '0;
         kind_q  <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         ill_q   <= ill_d;
         wrk_q   <= wrk_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a behavioural model.
module tb_alu_exec_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   alu_exec_if #(.XLEN(32)) bus ();
   alu_exec_unit #(.XLEN(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   always #5 clk = ~clk;

`ifdef ALU_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh = int'(b % 32);
      case (op)
         0, 1:    return a + b;
         2:       return a << sh;
         3:       return ($signed(a) < $signed(b)) ? 1 : 0;
         4:       return (a < b) ? 1 : 0;
         5:       return a ^ b;
         6:       return a >> sh;
         7:       return $unsigned($signed(a) >>> sh);
         8:       return a | b;
         9:       return a & b;
         10:      return a - b;
         11:      return (a == b) ? 1 : 0;
         12:      return (a != b) ? 1 : 0;
         13:      return ($signed(a) < $signed(b)) ? 1 : 0;
         14:      return ($signed(a) >= $signed(b)) ? 1 : 0;
         15:      return (a < b) ? 1 : 0;
         16:      return (a >= b) ? 1 : 0;
         17:      return a + 4;
         default: return 0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [5:0] op, input logic [31:0] b);
      if (!FAST && (op == 2 || op == 6 || op == 7)) return int'(b % 32) + 1;
      return 1;
   endfunction

   // Model: pending countdown until result appears, then held until taken
   logic        m_valid = 0, m_ill = 0, p_ill = 0;
   logic [31:0] m_res = 0, p_res = 0;
   int          m_pend = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 0; m_pend = 0; m_res = 0; m_ill = 0;
      end else if (bus.flush_i) begin
         m_valid = 0; m_pend = 0;
      end else if (m_valid) begin
         m_valid = !bus.ready_i;
      end else if (m_pend > 0) begin
         m_pend--;
         if (m_pend == 0) begin m_valid = 1; m_res = p_res; m_ill = p_ill; end
      end else if (bus.valid_i) begin
         p_res  = ref_alu(bus.alu_op_i, bus.op_a_i, bus.op_b_i);
         p_ill  = bus.alu_op_i > 17;
         m_pend = ref_lat(bus.alu_op_i, bus.op_b_i) - 1;
         if (m_pend == 0) begin m_valid = 1; m_res = p_res; m_ill = p_ill; end
      end
   end

   always @(negedge clk) begin
      chk("ready_o", 32'(bus.ready_o), 32'(!m_valid && m_pend == 0));
      chk("valid_o", 32'(bus.valid_o), 32'(m_valid));
      chk("result_o", bus.result_o, m_res);
      chk("illegal_o", 32'(bus.illegal_o), 32'(m_ill));
   end

   task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int lat);
      bus.valid_i = 1; bus.alu_op_i = op; bus.op_a_i = a; bus.op_b_i = b;
      @(posedge clk); #1;
      bus.valid_i = 0; bus.alu_op_i = 6'($urandom); bus.op_a_i = $urandom; bus.op_b_i = $urandom;
      lat = 1;
      while (!bus.valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
      r = bus.result_o;
   endtask

   task automatic release_res();
      bus.ready_i = 1;
      @(posedge clk); #1;
      bus.ready_i = 0;
   endtask

   initial begin
      logic [31:0] r;
      int lat;
      bus.valid_i = 0; bus.ready_i = 0; bus.flush_i = 0;
      bus.alu_op_i = 0; bus.op_a_i = 0; bus.op_b_i = 0;
      chk("model_sra", ref_alu(7, 32'h8000_0000, 32'h24), 32'hF800_0000);
      chk("model_bge", ref_alu(14, 32'hFFFF_FFFF, 1), 0);
      chk("model_jal", ref_alu(17, 32'hFFFF_FFFE, 0), 2);
      #1;
      chk("rst_valid", 32'(bus.valid_o), 0);
      chk("rst_result", bus.result_o, 0);
      chk("rst_illegal", 32'(bus.illegal_o), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      chk("rst_ready", 32'(bus.ready_o), 1);

      issue(0, 32'hFFFF_FFFF, 1, r, lat);
      chk("add_res", r, 0); chk("add_lat", lat, 1); chk("add_ill", 32'(bus.illegal_o), 0);
      release_res();

      issue(7, 32'h8000_0000, 32'h24, r, lat);
      chk("sra_res", r, 32'hF800_0000); chk("sra_lat", lat, FAST ? 1 : 5);
      release_res();

      issue(13, 32'hFFFF_FFFF, 1, r, lat); chk("blt_res", r, 1); release_res();
      issue(15, 32'hFFFF_FFFF, 1, r, lat); chk("bltu_res", r, 0); release_res();
      issue(3, 32'h1234_5678, 32'h1234_5678, r, lat); chk("slt_eq_res", r, 0); release_res();

      issue(10, 5, 7, r, lat);
      chk("sub_res", r, 32'hFFFF_FFFE);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("hold_res", bus.result_o, 32'hFFFF_FFFE);
         chk("hold_valid", 32'(bus.valid_o), 1);
         chk("hold_ready", 32'(bus.ready_o), 0);
      end
      release_res();

      bus.valid_i = 1; bus.alu_op_i = 2; bus.op_a_i = 1; bus.op_b_i = 31;
      @(posedge clk); #1;
      bus.valid_i = 0;
      for (int i = 0; i < 2; i++) begin
         if (!FAST) chk("flush_no_valid", 32'(bus.valid_o), 0);
         @(posedge clk); #1;
      end
      bus.flush_i = 1;
      @(posedge clk); #1;
      bus.flush_i = 0;
      chk("flush_ready", 32'(bus.ready_o), 1);
      chk("flush_valid", 32'(bus.valid_o), 0);
      issue(1, 3, 4, r, lat);
      chk("post_flush_add", r, 7); chk("post_flush_lat", lat, 1);
      release_res();

      issue(40, 32'hDEAD_BEEF, 9, r, lat);
      chk("illegal_res", r, 0); chk("illegal_flag", 32'(bus.illegal_o), 1);
      rst_n = 0;
      #1;
      chk("mid_rst_valid", 32'(bus.valid_o), 0);
      chk("mid_rst_result", bus.result_o, 0);
      chk("mid_rst_illegal", 32'(bus.illegal_o), 0);
      chk("mid_rst_ready", 32'(bus.ready_o), 1);
      @(posedge clk); #1 rst_n = 1;

      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         bus.valid_i  = 1'($urandom);
         bus.alu_op_i = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 17));
         bus.op_a_i   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 >> $urandom_range(0, 2) : $urandom;
         bus.op_b_i   = ($urandom_range(0, 3) == 0) ? bus.op_a_i : $urandom;
         bus.ready_i  = $urandom_range(0, 2) != 0;
         bus.flush_i  = $urandom_range(0, 31) == 0;
      end
      @(posedge clk); #1;
      bus.valid_i = 0; bus.flush_i = 0; bus.ready_i = 1;
      repeat (40) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
